// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: shared constants and types for the fabric configuration loader.
// Contents:
//   CFG_BITS / CFG_BYTES / SHADOW_BITS - configuration vector and frame sizing
//   SYNC_BYTE                           - frame start marker
//   <field>_LSB / <field>_W             - placement of each fabric field
//   cfg_state_e                         - loader FSM states
// Optional feature macro used by the loader: CFG_CHECKSUM_EN.
package fpga_cfg_pkg;

  localparam int CFG_BITS    = 871;
  localparam int CFG_BYTES   = 109;
  localparam int SHADOW_BITS = CFG_BYTES * 8;  // 872, top bit is padding

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam int BLE_LSB = 0;    localparam int BLE_W = 9;
  localparam int IO_LSB  = 9;    localparam int IO_W  = 4;
  localparam int LUT_LSB = 13;   localparam int LUT_W = 144;
  localparam int SB_LSB  = 157;  localparam int SB_W  = 240;
  localparam int CB_LSB  = 397;  localparam int CB_W  = 420;
  localparam int SDB_LSB = 817;  localparam int SDB_W = 36;
  localparam int SD_LSB  = 853;  localparam int SD_W  = 18;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CHECK  = 3'd2,
    COMMIT = 3'd3,
    ERROR  = 3'd4
  } cfg_state_e;

endpackage

// File: rtl/fpga_config_loader_cfg_checksum.sv
// cfg_checksum: 8-bit running-sum accumulator for the configuration frame.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clear       - zero the running sum (takes priority over en)
//   en          - add data into the running sum
//   data        - byte to accumulate / byte under test
//   zero        - (running sum + data) == 0 mod 256, used on the checksum byte
module cfg_checksum (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] data,
  output logic       zero
);

  logic [7:0] sum_q, sum_d;
  logic [7:0] sum_next;

  assign sum_next = sum_q + data;
  assign zero     = (sum_next == 8'h00);

  always_comb begin
    sum_d = sum_q;
    if (clear)   sum_d = 8'h00;
    else if (en) sum_d = sum_next;
  end

  always_ff @(posedge clk) begin
    if (reset) sum_q <= 8'h00;
    else       sum_q <= sum_d;
  end

endmodule

// File: rtl/fpga_config_loader.sv
// fpga_config_loader: byte-serial configuration controller for the 3x3 fabric.
// Receives a framed bitstream (SYNC_BYTE, 109 payload bytes LSB first, and a
// checksum byte when CFG_CHECKSUM_EN is defined), assembles it in a shadow
// register and commits it atomically to the fabric configuration outputs.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   cfg_data/cfg_valid/cfg_ready    - byte stream input
//   cfg_abort, cfg_clear            - drop frame in progress / clear sticky error
//   cfg_done, cfg_error, cfg_loaded - commit pulse, checksum error, config active
//   fabric_reset                    - holds the fabric in reset until loaded
//   BLE_dff_select .. sel_direction - active configuration fields
//   dbg_state                       - current FSM state for observation
// Optional feature: CFG_CHECKSUM_EN enables the checksum byte, CHECK/ERROR.
//
// Handshake: a byte transfers on a rising edge where cfg_valid & cfg_ready are
// both high. cfg_ready does not depend on cfg_valid; cfg_abort forces it low so
// an abort in the same cycle as a valid byte never accepts that byte.
module fpga_config_loader
  import fpga_cfg_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    cfg_data,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic          cfg_abort,
  input  logic          cfg_clear,
  output logic          cfg_done,
  output logic          cfg_error,
  output logic          cfg_loaded,
  output logic          fabric_reset,
  output logic [8:0]    BLE_dff_select,
  output logic [3:0]    IO_sel,
  output logic [143:0]  LUT_in,
  output logic [239:0]  SB_in,
  output logic [419:0]  CB_in,
  output logic [35:0]   sel_direction_BLEout,
  output logic [17:0]   sel_direction,
  output logic [2:0]    dbg_state
);

  cfg_state_e             state_q, state_d;
  logic [6:0]             cnt_q, cnt_d;
  logic [SHADOW_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0]    active_q, active_d;
  logic                   done_q, done_d;
  logic                   loaded_q, loaded_d;
  logic                   frst_q, frst_d;

  logic accept;
  logic last_byte;
  logic unused_pad;

  assign cfg_ready = !reset && !cfg_abort &&
                     (state_q == IDLE || state_q == LOAD || state_q == CHECK);
  assign accept    = cfg_valid && cfg_ready;
  assign last_byte = (cnt_q == 7'(CFG_BYTES - 1));
  // Shadow bit 871 is frame padding and never reaches the fabric.
  assign unused_pad = shadow_q[SHADOW_BITS-1];

`ifdef CFG_CHECKSUM_EN
  logic sum_clear, sum_en, sum_ok;
  assign sum_clear = (state_q == IDLE) && accept && (cfg_data == SYNC_BYTE);
  assign sum_en    = (state_q == LOAD) && accept;

  cfg_checksum u_checksum (
    .clk   (clk),
    .reset (reset),
    .clear (sum_clear),
    .en    (sum_en),
    .data  (cfg_data),
    .zero  (sum_ok)
  );
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    done_d   = 1'b0;
    loaded_d = loaded_q;
    unique case (state_q)
      IDLE: begin
        if (accept && cfg_data == SYNC_BYTE) begin
          cnt_d   = 7'd0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (cfg_abort) begin
          state_d = IDLE;
        end else if (accept) begin
          // Newest byte enters at the top; after 109 bytes byte 0 is at [7:0].
          shadow_d = {cfg_data, shadow_q[SHADOW_BITS-1:8]};
          cnt_d    = cnt_q + 7'd1;
          if (last_byte) begin
`ifdef CFG_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = COMMIT;
`endif
          end
        end
      end
      CHECK: begin
        if (cfg_abort) begin
          state_d = IDLE;
        end else if (accept) begin
`ifdef CFG_CHECKSUM_EN
          state_d = sum_ok ? COMMIT : ERROR;
`else
          state_d = IDLE;
`endif
        end
      end
      COMMIT: begin
        active_d = shadow_q[CFG_BITS-1:0];
        done_d   = 1'b1;
        loaded_d = 1'b1;
        state_d  = IDLE;
      end
      ERROR: begin
        if (cfg_clear) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Registered so the fabric is also held in reset throughout COMMIT.
    frst_d = !loaded_d || (state_d == COMMIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 7'd0;
      shadow_q <= '0;
      active_q <= '0;
      done_q   <= 1'b0;
      loaded_q <= 1'b0;
      frst_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      done_q   <= done_d;
      loaded_q <= loaded_d;
      frst_q   <= frst_d;
    end
  end

  assign cfg_done     = done_q;
  assign cfg_loaded   = loaded_q;
  assign fabric_reset = frst_q;
  assign dbg_state    = state_q;

`ifdef CFG_CHECKSUM_EN
  assign cfg_error = (state_q == ERROR);
`else
  assign cfg_error = 1'b0;
`endif

  assign BLE_dff_select       = active_q[BLE_LSB +: BLE_W];
  assign IO_sel               = active_q[IO_LSB  +: IO_W];
  assign LUT_in               = active_q[LUT_LSB +: LUT_W];
  assign SB_in                = active_q[SB_LSB  +: SB_W];
  assign CB_in                = active_q[CB_LSB  +: CB_W];
  assign sel_direction_BLEout = active_q[SDB_LSB +: SDB_W];
  assign sel_direction        = active_q[SD_LSB  +: SD_W];

endmodule

// File: tb/tb_fpga_config_loader.sv
// tb_fpga_config_loader: directed bench for fpga_config_loader. Frames are
// driven byte by byte; each frame expected to commit pushes its configuration
// into exp_q and a negedge monitor pops and compares on every cfg_done.
`timescale 1ns/1ps
module tb_fpga_config_loader;
  import fpga_cfg_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]   cfg_data;
  logic         cfg_valid, cfg_ready, cfg_abort, cfg_clear;
  logic         cfg_done, cfg_error, cfg_loaded, fabric_reset;
  logic [8:0]   BLE_dff_select;
  logic [3:0]   IO_sel;
  logic [143:0] LUT_in;
  logic [239:0] SB_in;
  logic [419:0] CB_in;
  logic [35:0]  sel_direction_BLEout;
  logic [17:0]  sel_direction;
  logic [2:0]   dbg_state;

  fpga_config_loader dut (
    .clk                  (clk),
    .reset                (reset),
    .cfg_data             (cfg_data),
    .cfg_valid            (cfg_valid),
    .cfg_ready            (cfg_ready),
    .cfg_abort            (cfg_abort),
    .cfg_clear            (cfg_clear),
    .cfg_done             (cfg_done),
    .cfg_error            (cfg_error),
    .cfg_loaded           (cfg_loaded),
    .fabric_reset         (fabric_reset),
    .BLE_dff_select       (BLE_dff_select),
    .IO_sel               (IO_sel),
    .LUT_in               (LUT_in),
    .SB_in                (SB_in),
    .CB_in                (CB_in),
    .sel_direction_BLEout (sel_direction_BLEout),
    .sel_direction        (sel_direction),
    .dbg_state            (dbg_state)
  );

  logic [CFG_BITS-1:0] act_cfg;
  assign act_cfg = {sel_direction, sel_direction_BLEout, CB_in, SB_in,
                    LUT_in, IO_sel, BLE_dff_select};

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [CFG_BITS-1:0] exp_q[$];
  logic prev_done = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void chk_cfg(string name, logic [CFG_BITS-1:0] exp);
    checks++;
    if (act_cfg !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act_cfg, exp);
    end
  endfunction

  always @(negedge clk) begin
    logic [CFG_BITS-1:0] e;
    if (prev_done) chk("done_one_cycle", cfg_done, 1'b0);
    if (cfg_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got cfg_done=1 expected no commit");
      end else begin
        e = exp_q.pop_front();
        chk_cfg("commit_cfg", e);
        chk("loaded_at_done", cfg_loaded, 1'b1);
        chk("fabric_reset_at_done", fabric_reset, 1'b0);
      end
    end
    prev_done = cfg_done;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish within 1ms");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end on a falling edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit took = 1'b0;
    cfg_data  = b;
    cfg_valid = 1'b1;
    for (int t = 0; t < 50 && !took; t++) begin
      #1;
      took = cfg_ready;
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    if (!took) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept of %0h", b);
    end
  endtask

  task automatic send_frame(input logic [SHADOW_BITS-1:0] p, input bit gaps,
                            input bit bad_cks);
    logic [7:0] sum = 8'h00;
    logic [7:0] b;
    if (!bad_cks) exp_q.push_back(p[CFG_BITS-1:0]);
    send_byte(SYNC_BYTE);
    for (int k = 0; k < CFG_BYTES; k++) begin
      if (gaps) idle($urandom_range(0, 2));
      b = p[8*k +: 8];
      sum = sum + b;
      send_byte(b);
    end
`ifdef CFG_CHECKSUM_EN
    b = 8'h00 - sum;
    if (bad_cks) b = b + 8'h01;
    send_byte(b);
`endif
  endtask

  // Called right after the final byte: the loader sits in COMMIT.
  task automatic check_commit_cycle();
    chk("commit_state", dbg_state, COMMIT);
    chk("commit_ready", cfg_ready, 1'b0);
    chk("commit_fabric_reset", fabric_reset, 1'b1);
    chk("commit_done_low", cfg_done, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  logic [SHADOW_BITS-1:0] p0, p1, p2, p3, p4;

  initial begin
    cfg_data = 8'h00; cfg_valid = 1'b0; cfg_abort = 1'b0; cfg_clear = 1'b0;
    p0 = '0;
    p1 = '0;
    p1[7:0]  = 8'hFF;
    p1[15:8] = 8'h1F;
    for (int k = 0; k < CFG_BYTES; k++) begin
      p2[8*k +: 8] = 8'(k * 37 + 11);
      p3[8*k +: 8] = ~8'(k);
      p4[8*k +: 8] = 8'($urandom);
    end

    repeat (3) @(negedge clk);
    chk("ready_in_reset", cfg_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk("rst_state", dbg_state, IDLE);
    chk_cfg("rst_cfg", '0);
    chk("rst_loaded", cfg_loaded, 1'b0);
    chk("rst_fabric_reset", fabric_reset, 1'b1);
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_error", cfg_error, 1'b0);
    chk("rst_ready", cfg_ready, 1'b1);
    @(negedge clk);

    // All-zero frame
    send_frame(p0, 1'b0, 1'b0);
    check_commit_cycle();
    idle(3);
    chk("zero_loaded", cfg_loaded, 1'b1);
    chk("zero_fabric_reset", fabric_reset, 1'b0);

    // Byte0=FF, byte1=1F
    send_frame(p1, 1'b0, 1'b0);
    check_commit_cycle();
    idle(3);
    chk("p1_ble", BLE_dff_select, 9'h1FF);
    chk("p1_io", IO_sel, 4'hF);
    chk("p1_lut_zero", 64'(LUT_in != '0), 64'd0);

`ifdef CFG_CHECKSUM_EN
    // Same frame with a wrong checksum byte
    send_frame(p1, 1'b0, 1'b1);
    chk("err_state", dbg_state, ERROR);
    chk("err_flag", cfg_error, 1'b1);
    chk("err_ready", cfg_ready, 1'b0);
    chk_cfg("err_cfg_kept", p1[CFG_BITS-1:0]);
    idle(3);
    chk("err_sticky", cfg_error, 1'b1);
    cfg_clear = 1'b1;
    @(negedge clk);
    cfg_clear = 1'b0;
    chk("clear_state", dbg_state, IDLE);
    chk("clear_error", cfg_error, 1'b0);
    chk("clear_ready", cfg_ready, 1'b1);
`else
    chk("error_tied_low", cfg_error, 1'b0);
`endif

    // Junk ahead of the sync byte
    send_byte(8'h00);
    send_byte(8'h5A);
    chk("junk_idle", dbg_state, IDLE);
    send_frame(p2, 1'b0, 1'b0);
    check_commit_cycle();
    idle(3);

    // Abort after 50 payload bytes, abort and valid together
    send_byte(SYNC_BYTE);
    for (int k = 0; k < 50; k++) send_byte(p3[8*k +: 8]);
    chk("reload_state", dbg_state, LOAD);
    chk_cfg("reload_old_cfg", p2[CFG_BITS-1:0]);
    chk("reload_loaded", cfg_loaded, 1'b1);
    chk("reload_fabric_reset", fabric_reset, 1'b0);
    cfg_abort = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 8'hC3;
    #1;
    chk("abort_ready", cfg_ready, 1'b0);
    @(negedge clk);
    cfg_abort = 1'b0;
    cfg_valid = 1'b0;
    chk("abort_state", dbg_state, IDLE);
    chk_cfg("abort_cfg_kept", p2[CFG_BITS-1:0]);
    send_frame(p3, 1'b0, 1'b0);
    check_commit_cycle();
    idle(3);

    // Reset in the middle of a gapped load
    send_byte(SYNC_BYTE);
    for (int k = 0; k < 30; k++) begin
      idle($urandom_range(0, 2));
      send_byte(p4[8*k +: 8]);
    end
    reset = 1'b1;
    @(negedge clk);
    chk_cfg("midrst_cfg", '0);
    chk("midrst_loaded", cfg_loaded, 1'b0);
    chk("midrst_fabric_reset", fabric_reset, 1'b1);
    chk("midrst_state", dbg_state, IDLE);
    chk("midrst_ready", cfg_ready, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    send_frame(p4, 1'b1, 1'b0);
    check_commit_cycle();
    idle(4);

    chk("exp_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpga_config_loader.md
# fpga_config_loader

Byte-serial configuration controller for the 3x3 fabric top level. It receives a framed bitstream over a valid/ready byte interface and assembles 871 configuration bits in a shadow register. It then commits them atomically to the fabric's configuration inputs (BLE_dff_select, IO_sel, LUT_in, SB_in, CB_in, sel_direction_BLEout, sel_direction). It also holds the fabric in reset until a valid configuration is active.

## Interface
- SYNC_BYTE, 8'hA5, frame start marker
- clk  in  1  fabric clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cfg_data  in  8  bitstream byte
- cfg_valid  in  1  cfg_data valid
- cfg_ready  out  1  loader accepts byte; transfer = cfg_valid & cfg_ready
- cfg_abort  in  1  discard frame in progress, return to IDLE
- cfg_clear  in  1  clear sticky error, return to IDLE
- cfg_done  out  1  one-cycle pulse on commit
- cfg_error  out  1  sticky checksum error
- cfg_loaded  out  1  a valid configuration is active
- fabric_reset  out  1  reset to fabric logic/IO blocks
- BLE_dff_select  out  9; IO_sel  out  4; LUT_in  out  144; SB_in  out  240; CB_in  out  420; sel_direction_BLEout  out  36; sel_direction  out  18 (active configuration)

## Operation
- Frame: SYNC_BYTE, 109 payload bytes (872 bits, LSB first), and one checksum byte when CFG_CHECKSUM_EN is defined.
- Payload bit 8k+j = byte k bit j. Bit 871 is padding and ignored.
- Field map of the 871-bit vector: [8:0] BLE_dff_select, [12:9] IO_sel, [156:13] LUT_in, [396:157] SB_in, [816:397] CB_in, [852:817] sel_direction_BLEout, [870:853] sel_direction.
- Shadow register is 872 bits. Each accepted payload byte shifts it right by 8 and enters at [871:864]. After 109 bytes, byte 0 sits at [7:0].
- States:
  - IDLE: accepted bytes that are not SYNC_BYTE are discarded. SYNC_BYTE clears the byte counter and the running sum, then goes to LOAD.
  - LOAD: accepts bytes. After the 109th byte, go to CHECK, or to COMMIT when the macro is absent.
  - CHECK: accepts one byte. Running sum + byte == 8'h00 (mod 256) goes to COMMIT; otherwise go to ERROR.
  - COMMIT: lasts one cycle with cfg_ready=0. At its closing edge, shadow[870:0] is copied to the active outputs, cfg_done pulses, cfg_loaded is set, and the state returns to IDLE.
  - ERROR: cfg_ready=0 and cfg_error=1 until cfg_clear, then IDLE. The active configuration is left unchanged.
- cfg_ready = !reset & !cfg_abort & state in {IDLE, LOAD, CHECK}.
- cfg_abort in LOAD or CHECK returns to IDLE and leaves the active configuration untouched. If abort and valid are both high in the same cycle, abort wins and no byte is accepted.
- cfg_clear outside ERROR has no effect.
- fabric_reset = !cfg_loaded | (state == COMMIT), registered. The fabric is reset on every reconfiguration.
- Once loaded, reloading keeps the old configuration active until the new commit.

## Timing
- Reset values: state IDLE, counter 0, sum 0, shadow 0, all configuration outputs 0, cfg_done 0, cfg_error 0, cfg_loaded 0, fabric_reset 1.
- Throughput is one byte per cycle. A full frame takes 111 accepts (110 without checksum), plus the 1-cycle COMMIT.
- Latency: the edge accepting the final byte enters COMMIT. The next edge updates the outputs, raises cfg_done for exactly one cycle, and drops fabric_reset.
- Gaps (cfg_valid=0) are allowed anywhere. Counter, sum and shadow hold during gaps.
- Reset mid-frame discards everything and reverts to the reset values, including the active configuration.

## Configuration
- CFG_CHECKSUM_EN defined: the checksum byte is required, CHECK and ERROR exist, and cfg_error is functional.
- CFG_CHECKSUM_EN undefined: there is no checksum byte, LOAD goes directly to COMMIT, and cfg_error is tied 0.

## Structure
- Package fpga_cfg_pkg holds:
  - CFG_BITS=871, CFG_BYTES=109, SYNC_BYTE default.
  - Per-field LSB/width constants.
  - State enum {IDLE, LOAD, CHECK, COMMIT, ERROR}.
- Sub-module cfg_checksum: 8-bit running-sum accumulator with clear and enable, plus a zero-check output. It is instantiated only under CFG_CHECKSUM_EN.

## Test plan
- Frame of 0xA5, 109 bytes 0x00, checksum 0x00 -> cfg_done one cycle after COMMIT; all outputs 0; cfg_loaded=1; fabric_reset falls.
- Payload byte 0 = 0xFF, byte 1 = 0x1F, rest 0, checksum 0xE2 -> BLE_dff_select=9'h1FF, IO_sel=4'hF, LUT_in=0.
- Same frame with checksum 0xE3 -> cfg_error=1, cfg_ready=0, outputs keep the prior values; after cfg_clear -> IDLE with cfg_ready=1.
- Leading bytes 0x00, 0x5A before 0xA5 -> junk bytes are ignored and the frame loads normally.
- cfg_abort asserted after payload byte 50 together with cfg_valid -> no accept, IDLE; a following full frame commits correctly.
- Random cfg_valid gaps, plus reset asserted mid-LOAD -> all outputs 0 and fabric_reset=1; a following frame commits correctly.
